// File: rtl/cpu_seq_ctrl_pkg.sv
// Opcode map, decode record and branch helpers shared by the sequencer.
// Opcodes occupy the low 5 bits of the instruction register.
package cpu_seq_ctrl_pkg;

  localparam int OPC_W = 5;
  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_NOP         = 5'h00;
  localparam opc_t OP_ADD         = 5'h01;
  localparam opc_t OP_SUB         = 5'h02;
  localparam opc_t OP_AND         = 5'h03;
  localparam opc_t OP_OR          = 5'h04;
  localparam opc_t OP_XOR         = 5'h05;
  localparam opc_t OP_SHL         = 5'h06;
  localparam opc_t OP_SHR         = 5'h07;
  localparam opc_t OP_INC         = 5'h08;
  localparam opc_t OP_DEC         = 5'h09;
  localparam opc_t OP_NOT         = 5'h0A;
  localparam opc_t OP_NEG         = 5'h0B;
  localparam opc_t OP_CLR         = 5'h0C;
  localparam opc_t OP_ABS         = 5'h0D;
  localparam opc_t OP_MAX         = 5'h0E;
  localparam opc_t OP_MIN         = 5'h0F;
  localparam opc_t OP_PASS_A      = 5'h10;
  localparam opc_t OP_PASS_B      = 5'h11;
  localparam opc_t OP_MOVE_REG_AX = 5'h12;
  localparam opc_t OP_MOVE_REG_XA = 5'h13;
  localparam opc_t OP_LDI_A       = 5'h14;
  localparam opc_t OP_JMP         = 5'h15;
  localparam opc_t OP_BEQ         = 5'h16;
  localparam opc_t OP_BCS         = 5'h17;
  localparam opc_t OP_BVS         = 5'h18;
  localparam opc_t OP_BMI         = 5'h19;
  localparam opc_t OP_HALT        = 5'h1A;

  typedef struct packed {
    opc_t alu_op;
    logic we_a;
    logic we_x;
    logic imm_sel;
    logic illegal;
  } dec_t;

  function automatic logic needs_imm(opc_t op);
    return op inside {OP_LDI_A, OP_JMP, OP_BEQ, OP_BCS, OP_BVS, OP_BMI};
  endfunction

  function automatic dec_t decode(opc_t op);
    dec_t d;
    d        = '0;
    d.alu_op = op;
    if (op >= OP_ADD && op <= OP_MIN) begin
      d.we_a = 1'b1;
    end else begin
      case (op)
        OP_NOP, OP_PASS_A, OP_PASS_B,
        OP_JMP, OP_BEQ, OP_BCS, OP_BVS, OP_BMI, OP_HALT: begin
        end
        OP_MOVE_REG_AX: d.we_a = 1'b1;
        OP_MOVE_REG_XA: d.we_x = 1'b1;
        OP_LDI_A: begin
          d.alu_op  = OP_PASS_B;
          d.imm_sel = 1'b1;
          d.we_a    = 1'b1;
        end
        // Undefined opcodes execute as a NOP but flag themselves.
        default: begin
          d.alu_op  = OP_NOP;
          d.illegal = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

  function automatic logic branch_taken(opc_t op, logic z, logic c, logic v, logic n);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_BEQ:  t = z;
      OP_BCS:  t = c;
      OP_BVS:  t = v;
      OP_BMI:  t = n;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_fetch_timer.sv
// Fetch watchdog: counts request cycles without ack, saturating at WAIT_MAX.
// expired_o is high once WAIT_MAX waiting cycles have elapsed; clear wins over count.
module cpu_fetch_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/exec sequencer: owns the PC, fetches opcode and optional immediate,
// drives registered ALU/write-enable controls for one EXEC cycle per instruction.
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int OP_W     = 5,
  parameter int PC_W     = 8,
  parameter int IMM_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exec_enable_i,
  input  logic             mode_run_i,
  input  logic             halt_req_i,
  input  logic             z_i,
  input  logic             c_i,
  input  logic             v_i,
  input  logic             n_i,
  input  logic             ifetch_ack_i,
  input  logic [IMM_W-1:0] ifetch_data_i,
  output logic             ifetch_req_o,
  output logic [PC_W-1:0]  pc_o,
  output logic [OP_W-1:0]  alu_op_o,
  output logic [IMM_W-1:0] imm_o,
  output logic             imm_sel_o,
  output logic             write_enable_a_o,
  output logic             write_enable_x_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic             illegal_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_OPER   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [OP_W-1:0]  ir_q, ir_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic             prev_en_q;

  logic             req_q, req_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic             imm_sel_q, imm_sel_d;
  logic             we_a_q, we_a_d;
  logic             we_x_q, we_x_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic             illegal_q, illegal_d;

  logic             start;
  logic             fetch_phase;
  logic             tmr_expired;
  dec_t             dec_nxt;
  logic             exec_nxt;

  assign start       = mode_run_i ? exec_enable_i : (exec_enable_i & ~prev_en_q);
  assign fetch_phase = (state_q == S_FETCH) || (state_q == S_OPER);

  // Clearing whenever we are not waiting covers both ack and fresh state entry.
  cpu_fetch_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_fetch_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (~fetch_phase | ifetch_ack_i),
    .count_en_i (fetch_phase & ~ifetch_ack_i),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      S_IDLE: begin
        if (halt_req_i) begin
          state_d = S_HALTED;
        end else if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (ifetch_ack_i) begin
          ir_d    = ifetch_data_i[OP_W-1:0];
          pc_d    = pc_q + PC_W'(1);
          state_d = needs_imm(opc_t'(ifetch_data_i[OP_W-1:0])) ? S_OPER : S_EXEC;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
        end
      end
      S_OPER: begin
        if (ifetch_ack_i) begin
          imm_d   = ifetch_data_i;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
        end
      end
      S_EXEC: begin
        if (branch_taken(opc_t'(ir_q), z_i, c_i, v_i, n_i)) begin
          pc_d = imm_q[PC_W-1:0];
        end
        if (opc_t'(ir_q) == OP_HALT || halt_req_i) begin
          state_d = S_HALTED;
        end else if (mode_run_i && exec_enable_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs are registered: decode the state and opcode being entered.
  always_comb begin
    dec_nxt   = decode(opc_t'(ir_d));
    exec_nxt  = (state_d == S_EXEC);
    req_d     = (state_d == S_FETCH) || (state_d == S_OPER);
    alu_op_d  = exec_nxt ? OP_W'(dec_nxt.alu_op) : '0;
    imm_sel_d = exec_nxt & dec_nxt.imm_sel;
    we_a_d    = exec_nxt & dec_nxt.we_a;
    we_x_d    = exec_nxt & dec_nxt.we_x;
    illegal_d = exec_nxt & dec_nxt.illegal;
    busy_d    = req_d | exec_nxt;
    halted_d  = (state_d == S_HALTED);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      imm_q     <= '0;
      prev_en_q <= 1'b0;
      req_q     <= 1'b0;
      alu_op_q  <= '0;
      imm_sel_q <= 1'b0;
      we_a_q    <= 1'b0;
      we_x_q    <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      prev_en_q <= exec_enable_i;
      req_q     <= req_d;
      alu_op_q  <= alu_op_d;
      imm_sel_q <= imm_sel_d;
      we_a_q    <= we_a_d;
      we_x_q    <= we_x_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  assign ifetch_req_o     = req_q;
  assign pc_o             = pc_q;
  assign alu_op_o         = alu_op_q;
  assign imm_o            = imm_q;
  assign imm_sel_o        = imm_sel_q;
  assign write_enable_a_o = we_a_q;
  assign write_enable_x_o = we_x_q;
  assign busy_o           = busy_q;
  assign halted_o         = halted_q;
  assign fault_o          = fault_q;
  assign illegal_o        = illegal_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: each issued instruction pushes its expected EXEC
// response; a monitor pops and compares whenever the DUT sits in EXEC (busy, no request).
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       exec_enable_i = 1'b0;
  logic       mode_run_i = 1'b0;
  logic       halt_req_i = 1'b0;
  logic       z_i = 1'b0, c_i = 1'b0, v_i = 1'b0, n_i = 1'b0;
  logic       ifetch_ack_i = 1'b0;
  logic [7:0] ifetch_data_i = 8'h00;

  logic       ifetch_req_o;
  logic [7:0] pc_o;
  logic [4:0] alu_op_o;
  logic [7:0] imm_o;
  logic       imm_sel_o, write_enable_a_o, write_enable_x_o;
  logic       busy_o, halted_o, fault_o, illegal_o;

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .exec_enable_i    (exec_enable_i),
    .mode_run_i       (mode_run_i),
    .halt_req_i       (halt_req_i),
    .z_i              (z_i),
    .c_i              (c_i),
    .v_i              (v_i),
    .n_i              (n_i),
    .ifetch_ack_i     (ifetch_ack_i),
    .ifetch_data_i    (ifetch_data_i),
    .ifetch_req_o     (ifetch_req_o),
    .pc_o             (pc_o),
    .alu_op_o         (alu_op_o),
    .imm_o            (imm_o),
    .imm_sel_o        (imm_sel_o),
    .write_enable_a_o (write_enable_a_o),
    .write_enable_x_o (write_enable_x_o),
    .busy_o           (busy_o),
    .halted_o         (halted_o),
    .fault_o          (fault_o),
    .illegal_o        (illegal_o)
  );

  typedef struct {
    logic [4:0] alu;
    logic       wa;
    logic       wx;
    logic       isel;
    logic       ill;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem [256];
  int         ack_delay = 0;
  bit         resp_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] alu, input bit wa, input bit wx, input bit isel,
                      input bit ill, input logic [7:0] imm, input logic [7:0] pc);
    exp_t e;
    e.alu = alu; e.wa = wa; e.wx = wx; e.isel = isel; e.ill = ill; e.imm = imm; e.pc = pc;
    expq.push_back(e);
  endtask

  // Memory responder: acks after ack_delay waiting cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (ifetch_req_o && !rst_i) begin
          if (wcnt >= ack_delay) begin
            ifetch_ack_i  = 1'b1;
            ifetch_data_i = mem[pc_o];
            wcnt          = 0;
          end else begin
            ifetch_ack_i = 1'b0;
            wcnt++;
          end
        end else begin
          ifetch_ack_i = 1'b0;
          wcnt         = 0;
        end
      end
    end
  end

  // Monitor: EXEC is the only busy state with no fetch request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && busy_o && !ifetch_req_o) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL exec_unexpected: alu_op=0x%0h pc=0x%0h with nothing expected", alu_op_o, pc_o);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("alu_op", alu_op_o, e.alu);
          chk("we_a", write_enable_a_o, e.wa);
          chk("we_x", write_enable_x_o, e.wx);
          chk("imm_sel", imm_sel_o, e.isel);
          chk("illegal", illegal_o, e.ill);
          chk("imm", imm_o, e.imm);
          @(negedge clk);
          chk("pc_after_exec", pc_o, e.pc);
        end
      end
    end
  end

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_bound", busy_o, 0);
  endtask

  task automatic step();
    @(negedge clk);
    exec_enable_i = 1'b1;
    @(negedge clk);
    exec_enable_i = 1'b0;
    wait_idle(60);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    exec_enable_i = 1'b0;
    halt_req_i = 1'b0;
    mode_run_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    foreach (mem[i]) mem[i] = 8'h00;

    // ---- reset state ----
    do_reset();
    chk("rst_pc", pc_o, 0);
    chk("rst_req", ifetch_req_o, 0);
    chk("rst_alu_op", alu_op_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_imm_sel", imm_sel_o, 0);
    chk("rst_we_a", write_enable_a_o, 0);
    chk("rst_we_x", write_enable_x_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_illegal", illegal_o, 0);

    // ---- single-step program, zero-wait ack ----
    mem[8'h00] = 8'h01;                       // ADD
    mem[8'h01] = 8'h13;                       // MOVE_REG_XA
    mem[8'h02] = 8'h10;                       // PASS_A
    mem[8'h03] = 8'h00;                       // NOP
    mem[8'h04] = 8'h16; mem[8'h05] = 8'h10;   // BEQ 0x10
    mem[8'h10] = 8'h16; mem[8'h11] = 8'h40;   // BEQ 0x40 (not taken)
    mem[8'h12] = 8'h17; mem[8'h13] = 8'h20;   // BCS 0x20
    mem[8'h20] = 8'h18; mem[8'h21] = 8'h30;   // BVS 0x30
    mem[8'h30] = 8'h19; mem[8'h31] = 8'h77;   // BMI 0x77 (not taken)
    mem[8'h32] = 8'h19; mem[8'h33] = 8'h40;   // BMI 0x40
    mem[8'h40] = 8'h1F;                       // undefined
    mem[8'h41] = 8'h14; mem[8'h42] = 8'h5A;   // LDI_A 0x5A
    mem[8'h43] = 8'h15; mem[8'h44] = 8'hFE;   // JMP 0xFE
    mem[8'hFE] = 8'h14; mem[8'hFF] = 8'h33;   // LDI_A 0x33, pc wraps to 0

    push(5'h01, 1, 0, 0, 0, 8'h00, 8'h01); step();
    chk("step_we_a_drop", write_enable_a_o, 0);
    chk("step_pc", pc_o, 1);
    push(5'h13, 0, 1, 0, 0, 8'h00, 8'h02); step();
    push(5'h10, 0, 0, 0, 0, 8'h00, 8'h03); step();
    push(5'h00, 0, 0, 0, 0, 8'h00, 8'h04); step();
    z_i = 1'b1; push(5'h16, 0, 0, 0, 0, 8'h10, 8'h10); step();
    z_i = 1'b0; push(5'h16, 0, 0, 0, 0, 8'h40, 8'h12); step();
    c_i = 1'b1; push(5'h17, 0, 0, 0, 0, 8'h20, 8'h20); step(); c_i = 1'b0;
    v_i = 1'b1; push(5'h18, 0, 0, 0, 0, 8'h30, 8'h30); step(); v_i = 1'b0;
    push(5'h19, 0, 0, 0, 0, 8'h77, 8'h32); step();
    n_i = 1'b1; push(5'h19, 0, 0, 0, 0, 8'h40, 8'h40); step(); n_i = 1'b0;
    push(5'h00, 0, 0, 0, 1, 8'h40, 8'h41); step();
    chk("illegal_pulse_end", illegal_o, 0);
    push(5'h11, 1, 0, 1, 0, 8'h5A, 8'h43); step();
    push(5'h15, 0, 0, 0, 0, 8'hFE, 8'hFE); step();
    push(5'h11, 1, 0, 1, 0, 8'h33, 8'h00); step();
    push(5'h01, 1, 0, 0, 0, 8'h33, 8'h01); step();

    // ---- free-run: LDI_A, INC, HALT ----
    do_reset();
    mem[8'h00] = 8'h14; mem[8'h01] = 8'h5A; mem[8'h02] = 8'h08; mem[8'h03] = 8'h1A;
    push(5'h11, 1, 0, 1, 0, 8'h5A, 8'h02);
    push(5'h08, 1, 0, 0, 0, 8'h5A, 8'h03);
    push(5'h1A, 0, 0, 0, 0, 8'h5A, 8'h04);
    @(negedge clk);
    mode_run_i = 1'b1;
    exec_enable_i = 1'b1;
    cyc = 0;
    for (int i = 0; i < 50 && !halted_o; i++) begin
      @(negedge clk);
      if (busy_o) cyc++;
    end
    chk("run_busy_cycles", cyc, 7);
    chk("run_halted", halted_o, 1);
    exec_enable_i = 1'b0;
    repeat (3) @(negedge clk);
    exec_enable_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt_sticky", halted_o, 1);
    chk("halt_busy", busy_o, 0);
    chk("halt_req_low", ifetch_req_o, 0);
    chk("halt_pc_hold", pc_o, 4);
    chk("halt_we_a", write_enable_a_o, 0);

    // ---- halt request during FETCH ----
    do_reset();
    mem[8'h00] = 8'h01;
    ack_delay = 3;
    push(5'h01, 1, 0, 0, 0, 8'h00, 8'h01);
    @(negedge clk);
    exec_enable_i = 1'b1;
    @(negedge clk);
    exec_enable_i = 1'b0;
    halt_req_i = 1'b1;
    for (int i = 0; i < 40 && !halted_o; i++) @(negedge clk);
    chk("haltreq_halted", halted_o, 1);
    chk("haltreq_pc", pc_o, 1);
    halt_req_i = 1'b0;

    // ---- fetch timeout ----
    do_reset();
    ack_delay = 15;
    push(5'h01, 1, 0, 0, 0, 8'h00, 8'h01); step();
    chk("wait15_no_fault", fault_o, 0);
    ack_delay = 16;
    step();
    chk("wait16_fault", fault_o, 1);
    chk("fault_req_low", ifetch_req_o, 0);
    chk("fault_busy", busy_o, 0);
    chk("fault_pc", pc_o, 1);
    exec_enable_i = 1'b1;
    repeat (5) @(negedge clk);
    exec_enable_i = 1'b0;
    chk("fault_sticky", fault_o, 1);
    do_reset();
    chk("fault_cleared", fault_o, 0);
    chk("fault_rst_pc", pc_o, 0);
    ack_delay = 0;

    // ---- reset in the middle of OPER, late ack ignored ----
    resp_en = 1'b0;
    ifetch_ack_i = 1'b0;
    @(negedge clk);
    exec_enable_i = 1'b1;
    @(negedge clk);
    exec_enable_i = 1'b0;
    ifetch_ack_i = 1'b1;
    ifetch_data_i = 8'h14;
    @(negedge clk);
    ifetch_ack_i = 1'b0;
    chk("oper_pc", pc_o, 1);
    chk("oper_req", ifetch_req_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_req_low", ifetch_req_o, 0);
    chk("midrst_pc", pc_o, 0);
    ifetch_ack_i = 1'b1;
    ifetch_data_i = 8'h99;
    @(negedge clk);
    ifetch_ack_i = 1'b0;
    @(negedge clk);
    chk("lateack_busy", busy_o, 0);
    chk("lateack_imm", imm_o, 0);
    chk("lateack_pc", pc_o, 0);
    resp_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
